tmr_alarm: RTL

- Bus-writable millisecond alarm that consumes the `ms_tick` strobe produced by the millisecond timer.
- Software writes a timeout in ms. The block counts it down on each tick, then raises an expiry flag and an interrupt.
- Supports one-shot and periodic modes.
- Sits on the same IO bus as the ms timer; the interrupt output goes to the interrupt controller.

---
 rtl/tmr_pkg.sv | 29 ++
 rtl/tmr_alarm_cnt.sv | 54 +++++
 rtl/tmr_alarm.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tmr_pkg.sv
// Shared definitions for the millisecond alarm: bus addresses, CTRL bit map, FSM states.
package tmr_pkg;

    localparam logic TMR_ALARM_ADDR_COUNT = 1'b0;
    localparam logic TMR_ALARM_ADDR_CTRL  = 1'b1;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_PER   = 1;
    localparam int unsigned CTRL_IRQEN = 2;
    localparam int unsigned CTRL_EXP   = 3;
    localparam int unsigned CTRL_OVR   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr_state_e;

    // Packs the CTRL/STATUS read word.
    function automatic logic [31:0] status_word(
        input logic overrun,
        input logic expired,
        input logic irq_en,
        input logic periodic,
        input logic en
    );
        return {27'b0, overrun, expired, irq_en, periodic, en};
    endfunction

endpackage

// File: rtl/tmr_alarm_cnt.sv
// Loadable millisecond down-counter with one-shot/periodic reload and an expiry strobe.
module tmr_alarm_cnt
    import tmr_pkg::*;
#(
    parameter int unsigned count_width = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   tick,
    input  logic                   load,
    input  logic [count_width-1:0] load_val,
    input  logic                   periodic,
    output logic [count_width-1:0] count,
    output logic                   expire
);

    logic [count_width-1:0] reload_q, reload_d;
    logic [count_width-1:0] count_q, count_d;
    logic                   at_one;

    assign at_one = (count_q == count_width'(1));
    // A load in the same cycle as a tick discards the tick, so no expiry either.
    assign expire = en & tick & ~load & at_one;
    assign count  = count_q;

    // Next reload/count: load wins, otherwise decrement or reload on a live tick; zero is held.
    always_comb begin
        reload_d = reload_q;
        count_d  = count_q;
        if (load) begin
            reload_d = load_val;
            count_d  = load_val;
        end else if (en && tick) begin
            if (at_one) begin
                count_d = periodic ? reload_q : '0;
            end else if (count_q != '0) begin
                count_d = count_q - count_width'(1);
            end
        end
    end

    // Counter and reload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
            count_q  <= '0;
        end else begin
            reload_q <= reload_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tmr_alarm.sv
// Bus-writable millisecond alarm: register decode, run/idle FSM, expiry flags and irq.
module tmr_alarm
    import tmr_pkg::*;
#(
    parameter int unsigned count_width = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stb,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic        ms_tick,
    output logic        irq
);

    tmr_state_e             state_q, state_d;
    logic                   periodic_q, periodic_d;
    logic                   irq_en_q, irq_en_d;
    logic                   expired_q, expired_d;
    logic                   overrun_q, overrun_d;
    logic                   irq_q, irq_d;

    logic                   wr_count;
    logic                   wr_ctrl;
    logic                   rd_en;
    logic                   run;
    logic                   expire;
    logic                   clr_exp;
    logic                   clr_ovr;
    logic [count_width-1:0] count;
    logic                   data_in_unused;

    assign ack      = stb;
    assign rd_en    = stb & ~we;
    assign wr_count = stb & we & (addr == TMR_ALARM_ADDR_COUNT);
    assign wr_ctrl  = stb & we & (addr == TMR_ALARM_ADDR_CTRL);
    assign clr_exp  = wr_ctrl & data_in[CTRL_EXP];
    assign clr_ovr  = wr_ctrl & data_in[CTRL_OVR];
    assign run      = (state_q == RUN);
    assign irq      = irq_q;

    // Upper write-data bits beyond the count width carry no meaning.
    assign data_in_unused = ^data_in;

    tmr_alarm_cnt #(
        .count_width (count_width)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run),
        .tick     (ms_tick),
        .load     (wr_count),
        .load_val (data_in[count_width-1:0]),
        .periodic (periodic_q),
        .count    (count),
        .expire   (expire)
    );

    // Next state for FSM, mode bits and flags. A CTRL write decides the run state
    // even against a one-shot expiry; an expiry always sets expired, overriding a clear.
    always_comb begin
        state_d    = state_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        expired_d  = expired_q;
        overrun_d  = overrun_q;
        irq_d      = expired_q & irq_en_q;

        if (wr_ctrl) begin
            state_d    = data_in[CTRL_EN] ? RUN : IDLE;
            periodic_d = data_in[CTRL_PER];
            irq_en_d   = data_in[CTRL_IRQEN];
        end else if (expire && !periodic_q) begin
            state_d = IDLE;
        end

        if (expire) begin
            expired_d = 1'b1;
        end else if (clr_exp) begin
            expired_d = 1'b0;
        end

        if (expire && expired_q && !clr_exp) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    // State, mode, flag and irq registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            expired_q  <= 1'b0;
            overrun_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            expired_q  <= expired_d;
            overrun_q  <= overrun_d;
            irq_q      <= irq_d;
        end
    end

    // Read mux: zero unless a read access is in progress.
    always_comb begin
        data_out = '0;
        if (rd_en) begin
            if (addr == TMR_ALARM_ADDR_CTRL) begin
                data_out = status_word(overrun_q, expired_q, irq_en_q, periodic_q, run);
            end else begin
                data_out = 32'(count);
            end
        end
    end

endmodule
